if_fetch: RTL and testbench

- Instruction fetch unit; producer end of the `instr` interface consumed by the decode stage.
- Generates instruction-memory read addresses and presents one 17-bit instruction per cycle to decode.
- Honours decode back-pressure (`stall_IM_ID`) and redirects on taken branches/jumps (`flow_change_ID_EX`).
- Instruction memory is synchronous: data returns exactly 1 cycle after the read, so a 1-entry hold buffer is required.

---
 rtl/if_fetch_pkg.sv | 42 ++++
 rtl/if_fetch_if.sv | 24 ++
 rtl/if_fetch_hold_buf.sv | 35 +++
 rtl/if_fetch.sv | 124 ++++++++++++
 tb/tb_if_fetch.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch/decode definitions: widths, NOP encoding, fetch state, hold entry.
package if_fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 17;
  localparam int unsigned OPC_W   = 5;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // Opcode field occupies the top OPC_W bits of an instruction.
  localparam logic [OPC_W-1:0] OPC_NOP = 5'h00;
  localparam logic [OPC_W-1:0] OPC_JAL = 5'h19;

  // Decode-side SRC1 selection; NPC2SRC1 consumes nxt_pc_IM_ID.
  typedef enum logic [1:0] {
    SRC1_RF  = 2'd0,
    SRC1_NPC = 2'd1,
    SRC1_IMM = 2'd2
  } src1_sel_e;

  localparam instr_t NOP_INSTR    = {OPC_NOP, {(INSTR_W - OPC_W){1'b0}}};
  localparam pc_t    DEF_RESET_PC = '0;

  // EMPTY: nothing to present; STREAM: read in flight; HELD: skid buffer full.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STREAM = 2'd1,
    ST_HELD   = 2'd2
  } fetch_state_e;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } hold_entry_t;

  // Sequential PC increment, wraps at 2^PC_W.
  function automatic pc_t pc_inc(input pc_t p);
    return p + PC_W'(1);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch -> decode instruction interface.
//   master (fetch):  drives instr, instr_vld, nxt_pc_IM_ID
//   slave  (decode): drives stall_IM_ID, flow_change_ID_EX, tgt_pc
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic   stall_IM_ID;
  logic   flow_change_ID_EX;
  pc_t    tgt_pc;
  instr_t instr;
  logic   instr_vld;
  pc_t    nxt_pc_IM_ID;

  modport master (
    input  stall_IM_ID, flow_change_ID_EX, tgt_pc,
    output instr, instr_vld, nxt_pc_IM_ID
  );

  modport slave (
    output stall_IM_ID, flow_change_ID_EX, tgt_pc,
    input  instr, instr_vld, nxt_pc_IM_ID
  );

endinterface

// File: rtl/if_fetch_hold_buf.sv
// 1-entry skid buffer holding a fetched instruction and its address while
// decode stalls.
//   cap   : load d, set vld
//   rls   : clear vld (entry consumed)
//   flush : clear vld (redirect), highest priority
//   vld/q : registered entry state
module fetch_hold_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap,
  input  logic        rls,
  input  logic        flush,
  input  hold_entry_t d,
  output logic        vld,
  output hold_entry_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= 1'b0;
      q.instr <= NOP_INSTR;
      q.pc    <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (cap) begin
      vld <= 1'b1;
      q   <= d;
    end else if (rls) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: issues synchronous IM reads, presents one
// instruction per cycle to decode, honours decode stall, redirects on
// taken branch/jump.
//   clk, rst_n        : clock, async active-low reset
//   dec (master)      : instr / instr_vld / nxt_pc_IM_ID out; stall, redirect in
//   im_re, im_addr    : IM read request (combinational)
//   im_rdata          : IM data, valid the cycle after im_re
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter pc_t RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_if.master        dec,
  output logic              im_re,
  output pc_t               im_addr,
  input  instr_t            im_rdata
);

  fetch_state_e state_q, state_d;
  pc_t          pc_q, pc_d;
  pc_t          rd_pc_q, rd_pc_d;
  logic         rd_pend;
  logic         out_vld;
  logic         hold_vld;
  hold_entry_t  hold_q;
  logic         cap, rls, flush;
  pc_t          sel_pc;

  assign rd_pend = (state_q == ST_STREAM);
  assign out_vld = hold_vld | rd_pend;

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      pc_q    <= RESET_PC;
      rd_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_pc_q <= rd_pc_d;
    end
  end

  // Next state, IM request and hold-buffer control.
  always_comb begin
    state_d = state_q;
    im_re   = 1'b1;
    im_addr = pc_q;
    pc_d    = pc_q;
    rd_pc_d = rd_pc_q;
    cap     = 1'b0;
    rls     = 1'b0;
    flush   = 1'b0;

    if (dec.flow_change_ID_EX) begin
      // Redirect overrides stall and discards any held instruction.
      im_addr = dec.tgt_pc;
      flush   = 1'b1;
      state_d = ST_STREAM;
    end else begin
      // Keep fetching unless a valid instruction is blocked by decode;
      // a stall with nothing valid still prefetches.
      im_re = !(dec.stall_IM_ID && out_vld);
      unique case (state_q)
        ST_EMPTY:  state_d = ST_STREAM;
        ST_STREAM: begin
          if (dec.stall_IM_ID) begin
            state_d = ST_HELD;
            cap     = 1'b1;
          end
        end
        ST_HELD: begin
          if (!dec.stall_IM_ID) begin
            state_d = ST_STREAM;
            rls     = 1'b1;
          end
        end
        default:   state_d = ST_EMPTY;
      endcase
    end

    if (im_re) begin
      pc_d    = pc_inc(im_addr);
      rd_pc_d = im_addr;
    end
  end

  fetch_hold_buf u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .cap   (cap),
    .rls   (rls),
    .flush (flush),
    .d     ('{instr: im_rdata, pc: rd_pc_q}),
    .vld   (hold_vld),
    .q     (hold_q)
  );

  // Presentation mux: held entry first, then the just-returned read.
  always_comb begin
    dec.instr     = NOP_INSTR;
    dec.instr_vld = 1'b0;
    sel_pc        = hold_q.pc;
    if (hold_vld) begin
      dec.instr     = hold_q.instr;
      dec.instr_vld = 1'b1;
      sel_pc        = hold_q.pc;
    end else if (rd_pend) begin
      dec.instr     = im_rdata;
      dec.instr_vld = 1'b1;
      sel_pc        = rd_pc_q;
    end
  end

  assign dec.nxt_pc_IM_ID = pc_inc(sel_pc);

  // The skid buffer and an in-flight read never coexist.
  a_hold_xor_pend: assert property (@(posedge clk) disable iff (!rst_n)
    !(hold_vld && rd_pend));

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch with a synchronous IM model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   im_re;
  pc_t    im_addr;
  instr_t im_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_if fe();

  if_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (fe),
    .im_re    (im_re),
    .im_addr  (im_addr),
    .im_rdata (im_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IM contents: distinct per address.
  function automatic instr_t mem(input pc_t a);
    return {a[3], a ^ 16'hC3A5};
  endfunction

  // Synchronous IM: data returns one cycle after the read; holds otherwise.
  always @(posedge clk) begin
    if (im_re) im_rdata <= mem(im_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    fe.stall_IM_ID = 1'b0;
    fe.flow_change_ID_EX = 1'b0;
    fe.tgt_pc = 16'h0000;
    tick; tick; #1;
    n_tests++; if (fe.instr !== 17'h0) begin n_fail++; $display("FAIL rst_instr: got %h want %h", fe.instr, 17'h0); end
    n_tests++; if (fe.instr_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b want 0", fe.instr_vld); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0001) begin n_fail++; $display("FAIL rst_nxt: got %h want 0001", fe.nxt_pc_IM_ID); end
    tick; rst_n = 1'b1; #1;
    n_tests++; if (im_re !== 1'b1) begin n_fail++; $display("FAIL rel_re: got %b want 1", im_re); end
    n_tests++; if (im_addr !== 16'h0000) begin n_fail++; $display("FAIL rel_addr: got %h want 0000", im_addr); end
    n_tests++; if (fe.instr_vld !== 1'b0) begin n_fail++; $display("FAIL rel_vld: got %b want 0", fe.instr_vld); end
  endtask

  task automatic test_stream;
    pc_t k;
    for (int i = 1; i <= 6; i++) begin
      k = 16'(i);
      tick; #1;
      n_tests++; if (im_addr !== k) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, im_addr, k); end
      n_tests++; if (fe.instr !== mem(k - 16'h1)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, fe.instr, mem(k - 16'h1)); end
      n_tests++; if (fe.nxt_pc_IM_ID !== k) begin n_fail++; $display("FAIL stream_nxt[%0d]: got %h want %h", i, fe.nxt_pc_IM_ID, k); end
      n_tests++; if (fe.instr_vld !== 1'b1) begin n_fail++; $display("FAIL stream_vld[%0d]: got %b want 1", i, fe.instr_vld); end
    end
  endtask

  // Entered in the cycle presenting IM[5].
  task automatic test_stall;
    fe.stall_IM_ID = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin tick; #1; end
      n_tests++; if (fe.instr !== mem(16'h0005)) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, fe.instr, mem(16'h0005)); end
      n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0006) begin n_fail++; $display("FAIL stall_nxt[%0d]: got %h want 0006", i, fe.nxt_pc_IM_ID); end
      n_tests++; if (im_re !== 1'b0) begin n_fail++; $display("FAIL stall_re[%0d]: got %b want 0", i, im_re); end
      n_tests++; if (fe.instr_vld !== 1'b1) begin n_fail++; $display("FAIL stall_vld[%0d]: got %b want 1", i, fe.instr_vld); end
    end
    tick; fe.stall_IM_ID = 1'b0; #1;
    n_tests++; if (fe.instr !== mem(16'h0005)) begin n_fail++; $display("FAIL release_instr: got %h want %h", fe.instr, mem(16'h0005)); end
    n_tests++; if (im_re !== 1'b1) begin n_fail++; $display("FAIL release_re: got %b want 1", im_re); end
    n_tests++; if (im_addr !== 16'h0006) begin n_fail++; $display("FAIL release_addr: got %h want 0006", im_addr); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0006)) begin n_fail++; $display("FAIL after_release_instr: got %h want %h", fe.instr, mem(16'h0006)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0007) begin n_fail++; $display("FAIL after_release_nxt: got %h want 0007", fe.nxt_pc_IM_ID); end
    n_tests++; if (im_addr !== 16'h0007) begin n_fail++; $display("FAIL after_release_addr: got %h want 0007", im_addr); end
  endtask

  task automatic test_redirect;
    tick; fe.flow_change_ID_EX = 1'b1; fe.tgt_pc = 16'h0040; #1;
    n_tests++; if (im_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_addr: got %h want 0040", im_addr); end
    n_tests++; if (im_re !== 1'b1) begin n_fail++; $display("FAIL redir_re: got %b want 1", im_re); end
    n_tests++; if (fe.instr !== mem(16'h0007)) begin n_fail++; $display("FAIL redir_cur_instr: got %h want %h", fe.instr, mem(16'h0007)); end
    tick; fe.flow_change_ID_EX = 1'b0; #1;
    n_tests++; if (fe.instr !== mem(16'h0040)) begin n_fail++; $display("FAIL redir_tgt_instr: got %h want %h", fe.instr, mem(16'h0040)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0041) begin n_fail++; $display("FAIL redir_tgt_nxt: got %h want 0041", fe.nxt_pc_IM_ID); end
    n_tests++; if (im_addr !== 16'h0041) begin n_fail++; $display("FAIL redir_next_addr: got %h want 0041", im_addr); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0041)) begin n_fail++; $display("FAIL redir_seq_instr: got %h want %h", fe.instr, mem(16'h0041)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0042) begin n_fail++; $display("FAIL redir_seq_nxt: got %h want 0042", fe.nxt_pc_IM_ID); end
  endtask

  task automatic test_redirect_held;
    tick; fe.stall_IM_ID = 1'b1; #1;
    n_tests++; if (fe.instr !== mem(16'h0042)) begin n_fail++; $display("FAIL rh_cap_instr: got %h want %h", fe.instr, mem(16'h0042)); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0042)) begin n_fail++; $display("FAIL rh_held_instr: got %h want %h", fe.instr, mem(16'h0042)); end
    n_tests++; if (im_re !== 1'b0) begin n_fail++; $display("FAIL rh_held_re: got %b want 0", im_re); end
    fe.flow_change_ID_EX = 1'b1; fe.tgt_pc = 16'h0100; #1;
    n_tests++; if (im_re !== 1'b1) begin n_fail++; $display("FAIL rh_redir_re: got %b want 1", im_re); end
    n_tests++; if (im_addr !== 16'h0100) begin n_fail++; $display("FAIL rh_redir_addr: got %h want 0100", im_addr); end
    tick; fe.flow_change_ID_EX = 1'b0; #1;
    n_tests++; if (fe.instr !== mem(16'h0100)) begin n_fail++; $display("FAIL rh_tgt_instr: got %h want %h", fe.instr, mem(16'h0100)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0101) begin n_fail++; $display("FAIL rh_tgt_nxt: got %h want 0101", fe.nxt_pc_IM_ID); end
    n_tests++; if (im_re !== 1'b0) begin n_fail++; $display("FAIL rh_tgt_re: got %b want 0", im_re); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0100)) begin n_fail++; $display("FAIL rh_tgt_held: got %h want %h", fe.instr, mem(16'h0100)); end
    n_tests++; if (im_re !== 1'b0) begin n_fail++; $display("FAIL rh_tgt_held_re: got %b want 0", im_re); end
    fe.stall_IM_ID = 1'b0; #1;
    n_tests++; if (im_addr !== 16'h0101) begin n_fail++; $display("FAIL rh_rel_addr: got %h want 0101", im_addr); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0101)) begin n_fail++; $display("FAIL rh_rel_next: got %h want %h", fe.instr, mem(16'h0101)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0102) begin n_fail++; $display("FAIL rh_rel_nxt: got %h want 0102", fe.nxt_pc_IM_ID); end
  endtask

  // Mid-operation reset, then stall held from the first cycle after reset.
  task automatic test_empty_stall;
    tick; rst_n = 1'b0; fe.stall_IM_ID = 1'b1; #1;
    n_tests++; if (fe.instr_vld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld: got %b want 0", fe.instr_vld); end
    n_tests++; if (fe.instr !== 17'h0) begin n_fail++; $display("FAIL mid_rst_instr: got %h want %h", fe.instr, 17'h0); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0001) begin n_fail++; $display("FAIL mid_rst_nxt: got %h want 0001", fe.nxt_pc_IM_ID); end
    tick; rst_n = 1'b1; #1;
    n_tests++; if (im_re !== 1'b1) begin n_fail++; $display("FAIL es_prefetch_re: got %b want 1", im_re); end
    n_tests++; if (im_addr !== 16'h0000) begin n_fail++; $display("FAIL es_prefetch_addr: got %h want 0000", im_addr); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0000)) begin n_fail++; $display("FAIL es_cap_instr: got %h want %h", fe.instr, mem(16'h0000)); end
    n_tests++; if (im_re !== 1'b0) begin n_fail++; $display("FAIL es_cap_re: got %b want 0", im_re); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0000)) begin n_fail++; $display("FAIL es_held_instr: got %h want %h", fe.instr, mem(16'h0000)); end
    tick; fe.stall_IM_ID = 1'b0; #1;
    n_tests++; if (fe.instr !== mem(16'h0000)) begin n_fail++; $display("FAIL es_rel_instr: got %h want %h", fe.instr, mem(16'h0000)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0001) begin n_fail++; $display("FAIL es_rel_nxt: got %h want 0001", fe.nxt_pc_IM_ID); end
    n_tests++; if (im_addr !== 16'h0001) begin n_fail++; $display("FAIL es_rel_addr: got %h want 0001", im_addr); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0001)) begin n_fail++; $display("FAIL es_next_instr: got %h want %h", fe.instr, mem(16'h0001)); end
  endtask

  task automatic test_wrap;
    tick; fe.flow_change_ID_EX = 1'b1; fe.tgt_pc = 16'hFFFE; #1;
    tick; fe.flow_change_ID_EX = 1'b0; #1;
    n_tests++; if (fe.instr !== mem(16'hFFFE)) begin n_fail++; $display("FAIL wrap_fffe_instr: got %h want %h", fe.instr, mem(16'hFFFE)); end
    n_tests++; if (im_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_fffe_addr: got %h want FFFF", im_addr); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'hFFFF)) begin n_fail++; $display("FAIL wrap_ffff_instr: got %h want %h", fe.instr, mem(16'hFFFF)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0000) begin n_fail++; $display("FAIL wrap_ffff_nxt: got %h want 0000", fe.nxt_pc_IM_ID); end
    n_tests++; if (im_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h want 0000", im_addr); end
    tick; #1;
    n_tests++; if (fe.instr !== mem(16'h0000)) begin n_fail++; $display("FAIL wrap_0_instr: got %h want %h", fe.instr, mem(16'h0000)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0001) begin n_fail++; $display("FAIL wrap_0_nxt: got %h want 0001", fe.nxt_pc_IM_ID); end
  endtask

  task automatic test_back_to_back;
    tick; fe.flow_change_ID_EX = 1'b1; fe.tgt_pc = 16'h0200; #1;
    n_tests++; if (im_addr !== 16'h0200) begin n_fail++; $display("FAIL b2b_first_addr: got %h want 0200", im_addr); end
    tick; fe.tgt_pc = 16'h0300; #1;
    n_tests++; if (im_addr !== 16'h0300) begin n_fail++; $display("FAIL b2b_second_addr: got %h want 0300", im_addr); end
    n_tests++; if (fe.instr !== mem(16'h0200)) begin n_fail++; $display("FAIL b2b_first_instr: got %h want %h", fe.instr, mem(16'h0200)); end
    tick; fe.flow_change_ID_EX = 1'b0; #1;
    n_tests++; if (fe.instr !== mem(16'h0300)) begin n_fail++; $display("FAIL b2b_second_instr: got %h want %h", fe.instr, mem(16'h0300)); end
    n_tests++; if (fe.nxt_pc_IM_ID !== 16'h0301) begin n_fail++; $display("FAIL b2b_second_nxt: got %h want 0301", fe.nxt_pc_IM_ID); end
    n_tests++; if (im_addr !== 16'h0301) begin n_fail++; $display("FAIL b2b_next_addr: got %h want 0301", im_addr); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_redirect_held;
    test_empty_stall;
    test_wrap;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
